// File: rtl/video_timing_monitor.sv
// video_timing_monitor
// Passive checker for an HS/VS/DE/RGB video stream. It measures line length,
// active pixels per line, lines per frame and active lines per frame, compares
// them against the expected timing, tracks lock through a small state machine
// and keeps a per-frame RGB checksum. Every output is registered.
//
// Ports:
//   Clock, Reset          pixel clock (posedge), asynchronous active-low reset
//   HS, VS, DE, R, G, B   video stream from the generator
//   ClearErr              one-cycle synchronous clear of the sticky ErrFlags
//   HTotal, HActive       last line length / last active line's DE count
//   VTotal, VActive       lines / active lines of the last complete frame
//   FrameSum              sum mod 2^16 of R+G+B over DE-high cycles of last frame
//   FrameCount            completed frames since reset (wraps)
//   MeasValid             one-cycle pulse when V measurements and FrameSum update
//   Locked                high while the timing is locked
//   ErrFlags              sticky mismatch bits {VActive, VTotal, HActive, HTotal}
module video_timing_monitor #(
  parameter int unsigned H_TOTAL     = 1056,
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_TOTAL     = 628,
  parameter int unsigned V_ACTIVE    = 600,
  parameter logic        SYNC_ACTIVE = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        DE,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  input  logic        ClearErr,
  output logic [11:0] HTotal,
  output logic [11:0] HActive,
  output logic [11:0] VTotal,
  output logic [11:0] VActive,
  output logic [15:0] FrameSum,
  output logic [15:0] FrameCount,
  output logic        MeasValid,
  output logic        Locked,
  output logic [3:0]  ErrFlags
);

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
  localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL);
  localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  // 12-bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic en);
    if (en && (v != 12'hFFF)) begin
      return v + 12'd1;
    end else begin
      return v;
    end
  endfunction

  // Input pipeline
  logic       hs_s1_r, hs_s2_r, vs_s1_r, vs_s2_r, de_s1_r;
  logic [7:0] r_s1_r, g_s1_r, b_s1_r;

  // Line / frame accumulators
  logic [11:0] line_cnt_r, de_cnt_r, v_tot_cnt_r, v_act_cnt_r;
  logic [15:0] sum_r;
  logic        hs_seen_r, frame_herr_r;

  // Output registers
  logic [11:0] htotal_r, hactive_r, vtotal_r, vactive_r;
  logic [15:0] frame_sum_r, frame_count_r;
  logic        meas_valid_r, locked_r;
  logic [3:0]  err_flags_r;

  // Control
  state_t     state_r, state_nx_s;
  logic [3:0] match_cnt_r, match_nx_s, match_inc_s;

  // Combinational helpers
  logic        hs_edge_s, vs_edge_s;
  logic [11:0] line_len_s, de_len_s, htot_eff_s, hact_eff_s, vtot_eff_s, vact_eff_s;
  logic        line_active_s, h_valid_s, hact_valid_s;
  logic        htot_mis_s, hact_mis_s, h_mis_s, frame_ok_s;
  logic [15:0] pix_sum_s, sum_eff_s;
  logic [3:0]  frame_err_s, err_set_s, err_nx_s;

  // Two-stage input registers; sync inputs reset to their inactive level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs_s1_r <= ~SYNC_ACTIVE;
      hs_s2_r <= ~SYNC_ACTIVE;
      vs_s1_r <= ~SYNC_ACTIVE;
      vs_s2_r <= ~SYNC_ACTIVE;
      de_s1_r <= 1'b0;
      r_s1_r  <= 8'd0;
      g_s1_r  <= 8'd0;
      b_s1_r  <= 8'd0;
    end else begin
      hs_s1_r <= HS;
      hs_s2_r <= hs_s1_r;
      vs_s1_r <= VS;
      vs_s2_r <= vs_s1_r;
      de_s1_r <= DE;
      r_s1_r  <= R;
      g_s1_r  <= G;
      b_s1_r  <= B;
    end
  end

  // Edge detection, per-line and per-frame values including the current cycle.
  // The edge cycle itself is counted as the last cycle of the ending line, and a
  // coincident HS edge is folded into the ending frame.
  always_comb begin
    hs_edge_s     = (hs_s1_r == SYNC_ACTIVE) && (hs_s2_r != SYNC_ACTIVE);
    vs_edge_s     = (vs_s1_r == SYNC_ACTIVE) && (vs_s2_r != SYNC_ACTIVE);
    line_len_s    = sat_inc(line_cnt_r, 1'b1);
    de_len_s      = sat_inc(de_cnt_r, de_s1_r);
    line_active_s = (de_len_s != 12'd0);
    // The first line after reset is partial and is never measured.
    h_valid_s     = hs_edge_s && hs_seen_r;
    // Blanking lines carry no DE, so HActive only tracks lines that had pixels.
    hact_valid_s  = h_valid_s && line_active_s;
    htot_mis_s    = h_valid_s && (line_len_s != H_TOTAL_C);
    hact_mis_s    = hact_valid_s && (de_len_s != H_ACTIVE_C);
    h_mis_s       = htot_mis_s || hact_mis_s;
    htot_eff_s    = h_valid_s ? line_len_s : htotal_r;
    hact_eff_s    = hact_valid_s ? de_len_s : hactive_r;
    vtot_eff_s    = sat_inc(v_tot_cnt_r, hs_edge_s);
    vact_eff_s    = sat_inc(v_act_cnt_r, hs_edge_s && line_active_s);
    pix_sum_s     = {8'd0, r_s1_r} + {8'd0, g_s1_r} + {8'd0, b_s1_r};
    sum_eff_s     = de_s1_r ? (sum_r + pix_sum_s) : sum_r;
    frame_err_s   = {(vact_eff_s != V_ACTIVE_C), (vtot_eff_s != V_TOTAL_C),
                     (hact_eff_s != H_ACTIVE_C), (htot_eff_s != H_TOTAL_C)};
    // A frame with any bad line anywhere is not a clean frame.
    frame_ok_s    = (frame_err_s == 4'd0) && !frame_herr_r && !h_mis_s;
    match_inc_s   = match_cnt_r + 4'd1;
  end

  // Line measurement: line/DE counters and the HTotal/HActive latches.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      line_cnt_r <= 12'd0;
      de_cnt_r   <= 12'd0;
      hs_seen_r  <= 1'b0;
      htotal_r   <= 12'd0;
      hactive_r  <= 12'd0;
    end else if (hs_edge_s) begin
      line_cnt_r <= 12'd0;
      de_cnt_r   <= 12'd0;
      hs_seen_r  <= 1'b1;
      if (h_valid_s) begin
        htotal_r <= line_len_s;
      end
      if (hact_valid_s) begin
        hactive_r <= de_len_s;
      end
    end else begin
      line_cnt_r <= line_len_s;
      de_cnt_r   <= de_len_s;
    end
  end

  // Frame accumulators and the V/checksum/frame-count latches.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      v_tot_cnt_r   <= 12'd0;
      v_act_cnt_r   <= 12'd0;
      sum_r         <= 16'd0;
      frame_herr_r  <= 1'b0;
      vtotal_r      <= 12'd0;
      vactive_r     <= 12'd0;
      frame_sum_r   <= 16'd0;
      frame_count_r <= 16'd0;
      meas_valid_r  <= 1'b0;
    end else if (vs_edge_s) begin
      v_tot_cnt_r  <= 12'd0;
      v_act_cnt_r  <= 12'd0;
      sum_r        <= 16'd0;
      frame_herr_r <= 1'b0;
      // The edge that leaves SEARCH closes a partial frame: nothing is reported.
      if (state_r != ST_SEARCH) begin
        vtotal_r      <= vtot_eff_s;
        vactive_r     <= vact_eff_s;
        frame_sum_r   <= sum_eff_s;
        frame_count_r <= frame_count_r + 16'd1;
        meas_valid_r  <= 1'b1;
      end else begin
        meas_valid_r  <= 1'b0;
      end
    end else begin
      v_tot_cnt_r  <= vtot_eff_s;
      v_act_cnt_r  <= vact_eff_s;
      sum_r        <= sum_eff_s;
      frame_herr_r <= frame_herr_r | h_mis_s;
      meas_valid_r <= 1'b0;
    end
  end

  // Lock state machine: next state and match counter.
  always_comb begin
    state_nx_s = state_r;
    match_nx_s = match_cnt_r;
    case (state_r)
      ST_SEARCH: begin
        if (vs_edge_s) begin
          state_nx_s = ST_ACQUIRE;
          match_nx_s = 4'd0;
        end else begin
          state_nx_s = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        if (vs_edge_s && frame_ok_s) begin
          match_nx_s = match_inc_s;
          if (match_inc_s >= LOCK_C) begin
            state_nx_s = ST_LOCKED;
          end else begin
            state_nx_s = ST_ACQUIRE;
          end
        end else if (vs_edge_s) begin
          match_nx_s = 4'd0;
          state_nx_s = ST_ACQUIRE;
        end else begin
          state_nx_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        // A bad line drops lock at once; a bad frame drops it at frame end.
        if (h_mis_s || (vs_edge_s && !frame_ok_s)) begin
          state_nx_s = ST_ERROR;
        end else begin
          state_nx_s = ST_LOCKED;
        end
      end
      ST_ERROR: begin
        if (vs_edge_s && frame_ok_s) begin
          state_nx_s = ST_ACQUIRE;
          match_nx_s = 4'd1;
        end else begin
          state_nx_s = ST_ERROR;
        end
      end
      default: begin
        state_nx_s = ST_SEARCH;
        match_nx_s = 4'd0;
      end
    endcase
  end

  // Sticky error flags: a new mismatch wins over a simultaneous clear.
  always_comb begin
    err_set_s = 4'd0;
    if (state_r != ST_SEARCH) begin
      err_set_s = {2'b00, hact_mis_s, htot_mis_s} | (vs_edge_s ? frame_err_s : 4'd0);
    end else begin
      err_set_s = 4'd0;
    end
    err_nx_s = (ClearErr ? 4'd0 : err_flags_r) | err_set_s;
  end

  // State, match counter and status registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_SEARCH;
      match_cnt_r <= 4'd0;
      locked_r    <= 1'b0;
      err_flags_r <= 4'd0;
    end else begin
      state_r     <= state_nx_s;
      match_cnt_r <= match_nx_s;
      locked_r    <= (state_nx_s == ST_LOCKED);
      err_flags_r <= err_nx_s;
    end
  end

  assign HTotal     = htotal_r;
  assign HActive    = hactive_r;
  assign VTotal     = vtotal_r;
  assign VActive    = vactive_r;
  assign FrameSum   = frame_sum_r;
  assign FrameCount = frame_count_r;
  assign MeasValid  = meas_valid_r;
  assign Locked     = locked_r;
  assign ErrFlags   = err_flags_r;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor using a scaled-down raster:
// 24 clocks/line (DE x=0..15, HS x=18..20), 12 lines/frame (DE lines 0..7,
// VS rising together with the HS of line 9 and lasting two lines).
module tb_video_timing_monitor;

  logic        clk, rst_n, hs, vs, de, clr;
  logic [7:0]  r, g, b;
  logic [11:0] htotal, hactive, vtotal, vactive;
  logic [15:0] frame_sum, frame_count;
  logic        meas_valid, locked;
  logic [3:0]  err_flags;

  int checks = 0;
  int failures = 0;
  int mv_hits;
  logic mv_at;

  // Gradient frame: sum over y<8, x<16 of x + y + 16 = 960 + 448 + 2048 = 3456.
  localparam logic [15:0] GRAD_SUM = 16'h0D80;
  // White frame: 128 pixels * 765 = 97920 mod 65536.
  localparam logic [15:0] WHITE_SUM = 16'h7E80;
  // Gradient with line 5 dropped: 3456 - (120 + 80 + 256).
  localparam logic [15:0] DROP5_SUM = 16'h0BB8;

  video_timing_monitor #(
    .H_TOTAL(24), .H_ACTIVE(16), .V_TOTAL(12), .V_ACTIVE(8),
    .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .Clock(clk), .Reset(rst_n), .HS(hs), .VS(vs), .DE(de),
    .R(r), .G(g), .B(b), .ClearErr(clr),
    .HTotal(htotal), .HActive(hactive), .VTotal(vtotal), .VActive(vactive),
    .FrameSum(frame_sum), .FrameCount(frame_count), .MeasValid(meas_valid),
    .Locked(locked), .ErrFlags(err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives lines y0..y1 one cycle per negedge, sampling outputs first.
  task automatic drive_lines(input int y0, input int y1, input int white,
                             input int stretch_y, input int drop_y,
                             input int clr_y, input int clr_x, input int force_y);
    mv_hits = 0;
    mv_at   = 1'b0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < ((y == stretch_y) ? 25 : 24); x++) begin
        @(negedge clk);
        if (meas_valid === 1'b1) mv_hits++;
        if (y == 9 && x == 20) mv_at = meas_valid;
        if (y == stretch_y + 1 && x == 19) check("locked_before_hs_err", 32'(locked), 32'd1);
        if (y == stretch_y + 1 && x == 20) begin
          check("locked_after_hs_err", 32'(locked), 32'd0);
          check("errflags_after_hs_err", 32'(err_flags), 32'h1);
        end
        if (y == force_y && x == 0) force dut.frame_count_r = 16'hFFFF;
        if (y == force_y && x == 1) release dut.frame_count_r;
        hs  = (x >= 18 && x <= 20 && x < 24);
        vs  = (y == 9 && x >= 18) || (y == 10) || (y == 11 && x < 18);
        de  = (y < 8 && x < 16 && y != drop_y);
        clr = (y == clr_y && x == clr_x);
        if (de) begin
          r = white ? 8'hFF : 8'(x);
          g = white ? 8'hFF : 8'(y);
          b = white ? 8'hFF : 8'h10;
        end else begin
          r = 8'hAA; g = 8'hAA; b = 8'hAA;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_htotal"}, 32'(htotal), 32'd0);
    check({tag, "_hactive"}, 32'(hactive), 32'd0);
    check({tag, "_vtotal"}, 32'(vtotal), 32'd0);
    check({tag, "_vactive"}, 32'(vactive), 32'd0);
    check({tag, "_fsum"}, 32'(frame_sum), 32'd0);
    check({tag, "_fcount"}, 32'(frame_count), 32'd0);
    check({tag, "_mv"}, 32'(meas_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err_flags), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; clr = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // A: first VS edge only leaves SEARCH
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("A_mv_hits", 32'(mv_hits), 32'd0);
    check("A_locked", 32'(locked), 32'd0);

    // B: first measured frame
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("B_mv_hits", 32'(mv_hits), 32'd1);
    check("B_mv_at", 32'(mv_at), 32'd1);
    check("B_htotal", 32'(htotal), 32'd24);
    check("B_hactive", 32'(hactive), 32'd16);
    check("B_vtotal", 32'(vtotal), 32'd12);
    check("B_vactive", 32'(vactive), 32'd8);
    check("B_fsum", 32'(frame_sum), 32'(GRAD_SUM));
    check("B_fcount", 32'(frame_count), 32'd1);
    check("B_locked", 32'(locked), 32'd0);
    check("B_err", 32'(err_flags), 32'd0);

    // C: second matching frame locks
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("C_locked", 32'(locked), 32'd1);
    check("C_fcount", 32'(frame_count), 32'd2);

    // D: white frame checksum
    drive_lines(0, 11, 1, -9, -1, -1, 0, -1);
    check("D_fsum", 32'(frame_sum), 32'(WHITE_SUM));
    check("D_locked", 32'(locked), 32'd1);
    check("D_err", 32'(err_flags), 32'd0);

    // E: line 3 stretched to 25 clocks
    drive_lines(0, 11, 0, 3, -1, -1, 0, -1);
    check("E_locked", 32'(locked), 32'd0);
    check("E_err", 32'(err_flags), 32'h1);
    check("E_htotal", 32'(htotal), 32'd24);

    // F: clean frame moves ERROR -> ACQUIRE; G: one more relocks
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("F_locked", 32'(locked), 32'd0);
    check("F_err_sticky", 32'(err_flags), 32'h1);
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("G_locked", 32'(locked), 32'd1);

    // H: ClearErr on a clean frame
    drive_lines(0, 11, 0, -9, -1, 2, 0, -1);
    check("H_err", 32'(err_flags), 32'd0);
    check("H_locked", 32'(locked), 32'd1);

    // I: DE dropped on line 5, ClearErr coincident with the VActive mismatch
    drive_lines(0, 11, 0, -9, 5, 9, 19, -1);
    check("I_vactive", 32'(vactive), 32'd7);
    check("I_vtotal", 32'(vtotal), 32'd12);
    check("I_hactive", 32'(hactive), 32'd16);
    check("I_fsum", 32'(frame_sum), 32'(DROP5_SUM));
    check("I_err", 32'(err_flags), 32'h8);
    check("I_locked", 32'(locked), 32'd0);

    // J: clean frame with ClearErr
    drive_lines(0, 11, 0, -9, -1, 1, 0, -1);
    check("J_err", 32'(err_flags), 32'd0);
    check("J_vactive", 32'(vactive), 32'd8);
    check("J_locked", 32'(locked), 32'd0);

    // Reset in the middle of a frame
    drive_lines(0, 4, 0, -9, -1, -1, 0, -1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_lines(5, 11, 0, -9, -1, -1, 0, -1);
    check("R1_mv_hits", 32'(mv_hits), 32'd0);
    drive_lines(0, 11, 0, -9, -1, -1, 0, -1);
    check("R2_mv_hits", 32'(mv_hits), 32'd1);
    check("R2_htotal", 32'(htotal), 32'd24);
    check("R2_vtotal", 32'(vtotal), 32'd12);
    check("R2_vactive", 32'(vactive), 32'd8);
    check("R2_fcount", 32'(frame_count), 32'd1);
    check("R2_locked", 32'(locked), 32'd0);

    // FrameCount preset to 0xFFFF wraps to 0 at the next frame
    drive_lines(0, 11, 0, -9, -1, -1, 0, 2);
    check("W_fcount", 32'(frame_count), 32'd0);
    check("W_err", 32'(err_flags), 32'd0);
    check("W_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
